melody_sequencer: RTL and testbench

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

---
 rtl/musicbox_pkg.sv | 37 +++
 rtl/beat_tick.sv | 39 +++
 rtl/melody_sequencer.sv | 147 ++++++++++++++
 tb/tb_melody_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/musicbox_pkg.sv
// Shared types and constants for the melody sequencer: FSM states, song-entry layout, sizes.
package musicbox_pkg;

    localparam int SONG_DEPTH = 64;
    localparam int ADDR_W     = 6;
    localparam int ENTRY_W    = 13;
    localparam int TEMPO_W    = 24;
    localparam int BAND_W     = 3;
    localparam int NOTE_W     = 4;
    localparam int LEN_W      = 4;

    localparam logic [BAND_W-1:0] BAND_RESET = 3'h4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        PLAY,
        GAP,
        PAUSED,
        DONE
    } state_e;

    // Field order mirrors the packed song word: [12] eos, [11] rest, [10:8] band, [7:4] note, [3:0] len.
    typedef struct packed {
        logic              eos;
        logic              rest;
        logic [BAND_W-1:0] band;
        logic [NOTE_W-1:0] note;
        logic [LEN_W-1:0]  len;
    } entry_t;

    function automatic logic [15:0] note_onehot(input logic [NOTE_W-1:0] note, input logic rest);
        return rest ? 16'h0000 : (16'h0001 << note);
    endfunction

endpackage

// File: rtl/beat_tick.sv
// Tempo divider: emits a one-cycle tick every tempo_div clocks (0 behaves as 1).
// The period is re-sampled only at clear and at each tick, so tempo changes land on tick boundaries.
module beat_tick
    import musicbox_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               hold,
    input  logic [TEMPO_W-1:0] tempo_div,
    output logic               tick
);

    logic [TEMPO_W-1:0] cnt_q;
    logic [TEMPO_W-1:0] period_q;
    logic [TEMPO_W-1:0] tempo_eff;

    assign tempo_eff = (tempo_div == '0) ? TEMPO_W'(1) : tempo_div;
    assign tick      = !clr && !hold && (cnt_q == period_q - TEMPO_W'(1));

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            period_q <= TEMPO_W'(1);
        end else if (clr) begin
            cnt_q    <= '0;
            period_q <= tempo_eff;
        end else if (!hold) begin
            if (tick) begin
                cnt_q    <= '0;
                period_q <= tempo_eff;
            end else begin
                cnt_q <= cnt_q + TEMPO_W'(1);
            end
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Song-RAM driven melody sequencer with play/gap timing, pause/resume and stop.
// Define MELODY_LOOP_EN to make an eos entry restart the song instead of finishing.
module melody_sequencer
    import musicbox_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [TEMPO_W-1:0] tempo_div,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    output logic [15:0]        note_sw,
    output logic [BAND_W-1:0]  band_o,
    output logic               adj_o,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  addr
);

    logic [ENTRY_W-1:0] mem [SONG_DEPTH];
    entry_t             rd_q;

    state_e             state_q, saved_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [15:0]        note_sw_q, note_q;
    logic [BAND_W-1:0]  band_q;
    logic [LEN_W-1:0]   dur_q;
    logic               done_q;
    logic               tick;

    state_e             step_state_d;
    logic [LEN_W-1:0]   step_dur_d;
    logic [ADDR_W-1:0]  step_addr_d;

    // NOTE: the song RAM has no reset; its contents must survive rst_n, and a reset port would block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (state_q == FETCH) rd_q <= mem[addr_q];
    end

    beat_tick u_beat_tick (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (state_q == DECODE),
        .hold      (state_q == PAUSED),
        .tempo_div (tempo_div),
        .tick      (tick)
    );

    // Where PLAY/GAP would go after this cycle; also what PAUSED resumes into.
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        step_state_d = state_q;
        step_dur_d   = dur_q;
        step_addr_d  = addr_q;
        if (tick && state_q == PLAY) begin
            if (dur_q == '0) step_state_d = GAP;
            else             step_dur_d   = dur_q - LEN_W'(1);
        end else if (tick && state_q == GAP) begin
            step_state_d = FETCH;
            step_addr_d  = addr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            saved_q   <= IDLE;
            addr_q    <= '0;
            note_sw_q <= '0;
            note_q    <= '0;
            band_q    <= BAND_RESET;
            dur_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (stop) begin
                state_q   <= IDLE;
                addr_q    <= '0;
                note_sw_q <= '0;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start) begin
                            state_q <= FETCH;
                            addr_q  <= '0;
                        end
                    end
                    FETCH: state_q <= DECODE;
                    DECODE: begin
                        note_sw_q <= '0;
                        if (rd_q.eos) begin
`ifdef MELODY_LOOP_EN
                            if (addr_q != '0) begin
                                addr_q  <= '0;
                                state_q <= FETCH;
                            end else begin
                                state_q <= DONE;
                                done_q  <= 1'b1;
                            end
`else
                            state_q <= DONE;
                            done_q  <= 1'b1;
`endif
                        end else begin
                            band_q    <= rd_q.band;
                            note_q    <= note_onehot(rd_q.note, rd_q.rest);
                            note_sw_q <= note_onehot(rd_q.note, rd_q.rest);
                            dur_q     <= rd_q.len;
                            state_q   <= PLAY;
                        end
                    end
                    PLAY, GAP: begin
                        dur_q  <= step_dur_d;
                        addr_q <= step_addr_d;
                        if (pause) begin
                            state_q   <= PAUSED;
                            saved_q   <= step_state_d;
                            note_sw_q <= '0;
                        end else begin
                            state_q   <= step_state_d;
                            note_sw_q <= (step_state_d == PLAY) ? note_q : '0;
                        end
                    end
                    PAUSED: begin
                        if (pause) begin
                            state_q   <= saved_q;
                            note_sw_q <= (saved_q == PLAY) ? note_q : '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign note_sw = note_sw_q;
    assign band_o  = band_q;
    assign busy    = (state_q != IDLE) && (state_q != DONE);
    assign adj_o   = busy;
    assign done    = done_q;
    assign addr    = addr_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: expected note_sw runs (value, cycle count while busy)
// are queued when playback is started and compared as the DUT finishes each run.
module tb_melody_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, stop = 1'b0, pause = 1'b0;
    logic [23:0] tempo_div = 24'd4;
    logic        wr_en = 1'b0;
    logic [5:0]  wr_addr = '0;
    logic [12:0] wr_data = '0;
    logic [15:0] note_sw;
    logic [2:0]  band_o;
    logic        adj_o, busy, done;
    logic [5:0]  addr;

    melody_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .pause     (pause),
        .tempo_div (tempo_div),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .note_sw   (note_sw),
        .band_o    (band_o),
        .adj_o     (adj_o),
        .busy      (busy),
        .done      (done),
        .addr      (addr)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [15:0] note;
        int          len;
    } seg_t;

    seg_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          d0;
    bit          mon_en = 1'b0;
    bit          in_run = 1'b0;
    logic [15:0] run_note = '0;
    int          run_len = 0;
    string       scen = "reset";

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s/%s: got 0x%0h, expected 0x%0h", scen, tag, got, exp);
        end
    endtask

    function automatic logic [12:0] mk(input logic eos, input logic rest, input logic [2:0] band,
                                       input logic [3:0] note, input logic [3:0] len);
        return {eos, rest, band, note, len};
    endfunction

    task automatic push(input logic [15:0] n, input int l);
        seg_t s;
        s.note = n;
        s.len  = l;
        exp_q.push_back(s);
    endtask

    task automatic emit_run();
        seg_t e;
        if (!mon_en) return;
        if (exp_q.size() == 0) begin
            check("unexpected_run", run_len, 0);
            return;
        end
        e = exp_q.pop_front();
        check("seg_note", run_note, e.note);
        check("seg_len", run_len, e.len);
    endtask

    // Collapse note_sw into runs while busy; a run ends on a value change or when busy drops.
    always begin
        @(posedge clk);
        #1;
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) begin
            if (in_run && note_sw === run_note) begin
                run_len++;
            end else begin
                if (in_run) emit_run();
                run_note = note_sw;
                run_len  = 1;
                in_run   = 1'b1;
            end
        end else if (in_run) begin
            emit_run();
            in_run = 1'b0;
        end
    end

    task automatic write_entry(input logic [5:0] a, input logic [12:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (busy && n < budget);
        check(tag, busy, 1'b0);
        @(negedge clk);
        check("sb_drained", exp_q.size(), 0);
    endtask

    task automatic wait_note(input string tag, input logic [15:0] want, input int budget);
        int n = 0;
        while (note_sw !== want && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, note_sw, want);
    endtask

    task automatic wait_addr(input string tag, input logic [5:0] want, input int budget);
        int n = 0;
        while (addr !== want && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, addr, want);
    endtask

    task automatic cycles_until_addr_change(output int n);
        logic [5:0] a0;
        a0 = addr;
        n  = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (addr === a0 && n < 20);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state while rst_n is held low
        repeat (3) @(posedge clk);
        #1;
        check("rst_note_sw", note_sw, 16'h0000);
        check("rst_band", band_o, 3'h4);
        check("rst_busy", busy, 1'b0);
        check("rst_adj", adj_o, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", addr, 6'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Play: note 2 band 5 len 1 at tempo 4, then eos
        scen = "play";
        write_entry(6'd0, mk(1'b0, 1'b0, 3'd5, 4'd2, 4'd1));
        write_entry(6'd1, mk(1'b1, 1'b0, 3'd0, 4'd0, 4'd0));
        tempo_div = 24'd4;
        push(16'h0000, 2);
        push(16'h0004, 8);
        push(16'h0000, 6);
        d0 = done_cnt;
        pulse_start();
        wait_note("note_on", 16'h0004, 10);
        check("band", band_o, 3'd5);
        check("adj_busy", adj_o, 1'b1);
        wait_idle("finish", 60);
        check("done_pulse", done_cnt - d0, 1);
        check("done_addr", addr, 6'd1);
        check("done_silent", note_sw, 16'h0000);

        // Read-during-write on the fetched address returns the old entry
        scen = "rdw";
        write_entry(6'd0, mk(1'b0, 1'b0, 3'd1, 4'd5, 4'd0));
        tempo_div = 24'd2;
        push(16'h0000, 2);
        push(16'h0020, 2);
        push(16'h0000, 4);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        wr_en   = 1'b1;
        wr_addr = 6'd0;
        wr_data = mk(1'b0, 1'b0, 3'd1, 4'd6, 4'd0);
        @(negedge clk);
        wr_en = 1'b0;
        wait_idle("old_data", 40);
        push(16'h0000, 2);
        push(16'h0040, 2);
        push(16'h0000, 4);
        pulse_start();
        wait_idle("new_data", 40);

        // Rest entry: silent but busy, address advances by one
        scen = "rest";
        write_entry(6'd0, mk(1'b0, 1'b1, 3'd3, 4'd9, 4'd0));
        tempo_div = 24'd3;
        push(16'h0000, 10);
        d0 = done_cnt;
        pulse_start();
        wait_idle("finish", 40);
        check("addr_adv", addr, 6'd1);
        check("band", band_o, 3'd3);
        check("done_pulse", done_cnt - d0, 1);

        // Pause two cycles into a 12-cycle note, hold 10 cycles, resume
        scen = "pause";
        write_entry(6'd0, mk(1'b0, 1'b0, 3'd2, 4'd7, 4'd2));
        tempo_div = 24'd4;
        push(16'h0000, 2);
        push(16'h0080, 2);
        push(16'h0000, 10);
        push(16'h0080, 10);
        push(16'h0000, 6);
        pulse_start();
        wait_note("note_on", 16'h0080, 10);
        @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        check("paused_silent", note_sw, 16'h0000);
        check("paused_busy", busy, 1'b1);
        repeat (9) @(negedge clk);
        pause = 1'b1;
        @(negedge clk);
        pause = 1'b0;
        wait_idle("finish", 60);

        // stop + pause + start together during PLAY: stop wins
        scen = "priority";
        mon_en = 1'b0;
        write_entry(6'd0, mk(1'b0, 1'b0, 3'd1, 4'd1, 4'd0));
        write_entry(6'd1, mk(1'b0, 1'b0, 3'd6, 4'd9, 4'd15));
        write_entry(6'd2, mk(1'b1, 1'b0, 3'd0, 4'd0, 4'd0));
        tempo_div = 24'd2;
        pulse_start();
        wait_note("second_note", 16'h0200, 30);
        check("addr_before", addr, 6'd1);
        repeat (3) @(negedge clk);
        stop  = 1'b1;
        pause = 1'b1;
        start = 1'b1;
        @(negedge clk);
        stop  = 1'b0;
        pause = 1'b0;
        start = 1'b0;
        check("busy", busy, 1'b0);
        check("addr", addr, 6'd0);
        check("note_sw", note_sw, 16'h0000);
        repeat (3) @(negedge clk);
        check("stays_idle", busy, 1'b0);

        // Reset mid-PLAY silences on the same edge and keeps RAM
        scen = "midreset";
        write_entry(6'd0, mk(1'b0, 1'b0, 3'd7, 4'd3, 4'd7));
        write_entry(6'd1, mk(1'b1, 1'b0, 3'd0, 4'd0, 4'd0));
        pulse_start();
        wait_note("note_on", 16'h0008, 10);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("note_sw", note_sw, 16'h0000);
        check("band", band_o, 3'h4);
        check("busy", busy, 1'b0);
        check("addr", addr, 6'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        push(16'h0000, 2);
        push(16'h0008, 16);
        push(16'h0000, 4);
        pulse_start();
        wait_note("ram_kept", 16'h0008, 10);
        check("band_kept", band_o, 3'd7);
        wait_idle("finish", 60);

        // 64 entries without eos, tempo_div=0 behaves as 1: address wraps 63 -> 0
        scen = "wrap";
        mon_en = 1'b0;
        for (int a = 0; a < 64; a++) write_entry(a[5:0], mk(1'b0, 1'b0, a[2:0], a[3:0], 4'd0));
        tempo_div = 24'd0;
        pulse_start();
        wait_addr("reach_62", 6'd62, 400);
        cycles_until_addr_change(n);
        check("entry_cycles", n, 4);
        check("addr_63", addr, 6'd63);
        cycles_until_addr_change(n);
        check("wrap_cycles", n, 4);
        check("wrap_addr", addr, 6'd0);
        check("wrap_busy", busy, 1'b1);
        pulse_stop();
        check("stopped", busy, 1'b0);

`ifdef MELODY_LOOP_EN
        // Loop build: eos at entry 3 restarts at 0 without done; eos at entry 0 still finishes
        scen = "loop";
        for (int a = 0; a < 3; a++) write_entry(a[5:0], mk(1'b0, 1'b0, 3'd1, a[3:0], 4'd0));
        write_entry(6'd3, mk(1'b1, 1'b0, 3'd0, 4'd0, 4'd0));
        tempo_div = 24'd1;
        d0 = done_cnt;
        pulse_start();
        wait_addr("reach_3", 6'd3, 40);
        cycles_until_addr_change(n);
        check("loop_addr", addr, 6'd0);
        check("loop_busy", busy, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("no_done", done_cnt - d0, 0);
        pulse_stop();
        write_entry(6'd0, mk(1'b1, 1'b0, 3'd0, 4'd0, 4'd0));
        d0 = done_cnt;
        pulse_start();
        wait_idle("empty_song", 20);
        check("empty_done", done_cnt - d0, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
